gate_sweep_ctrl: RTL and testbench
==================================

GATE_SWEEP_CTRL -- requirements
Module: gate_sweep_ctrl

Interface
REQ-001 SHALL have parameter SETTLE_CYCLES, default 4, range 1..255: cycles each input vector is held before gate_y is sampled.
REQ-002 SHALL have port clk  input  1  rising-edge clock; the single clock domain.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port start  input  1  run request, sampled on the rising edge.
REQ-005 SHALL have port truth_table  input  4  expected output per vector k; bit k corresponds to {a,b}=k.
REQ-006 SHALL have port gate_y  input  1  output of the gate under control.
REQ-007 SHALL have port gate_a  output  1  drive to the gate's a input.
REQ-008 SHALL have port gate_b  output  1  drive to the gate's b input.
REQ-009 SHALL have port busy  output  1  high while a sweep is running.
REQ-010 SHALL have port done  output  1  high when a sweep has completed.
REQ-011 SHALL have port pass  output  1  high when done is high and no vector mismatched.
REQ-012 SHALL have port err_count  output  3  mismatch count, 0..4.
REQ-013 SHALL have port fail_mask  output  4  bit k set when vector k mismatched.

Function
REQ-014 SHALL implement FSM states IDLE, DRIVE, SETTLE, SAMPLE, DONE.
REQ-015 SHALL move IDLE->DRIVE, or DONE->DRIVE, on start=1; truth_table is captured at that edge; k=0; err_count and fail_mask clear; done drops.
REQ-016 SHALL ignore start while busy, i.e. in DRIVE, SETTLE or SAMPLE; truth_table changes mid-run have no effect.
REQ-017 SHALL drive gate_a=k[1], gate_b=k[0] in DRIVE, SETTLE and SAMPLE; gate_a=gate_b=0 in IDLE and DONE.
REQ-018 SHALL stay in DRIVE 1 cycle, then SETTLE exactly SETTLE_CYCLES cycles, then SAMPLE 1 cycle; each vector occupies SETTLE_CYCLES+2 cycles.
REQ-019 SHALL compare gate_y with captured truth_table[k] in SAMPLE; on mismatch, set fail_mask[k] and increment err_count (saturation not needed, max 4).
REQ-020 SHALL go SAMPLE->DRIVE with k+1 when k<3, and SAMPLE->DONE when k==3; k never wraps within a run.
REQ-021 SHALL assert done 4*(SETTLE_CYCLES+2) cycles after the edge that accepted start, and hold it until the next accepted start or reset.
REQ-022 SHALL make pass = done AND (err_count==0); pass is 0 whenever done is 0.
REQ-023 SHALL assert busy exactly in DRIVE, SETTLE and SAMPLE; busy and done are never both high.
REQ-024 SHALL treat start held high in DONE as an immediate restart; in IDLE, start held high starts exactly one run at a time.
REQ-025 SHALL register all outputs, with no combinational path from gate_y to any output.

Reset
REQ-026 SHALL, while rst_n=0 and independent of clk, force state=IDLE, k=0, gate_a=0, gate_b=0, busy=0, done=0, pass=0, err_count=0, fail_mask=0.
REQ-027 SHALL abort any sweep in progress on reset, with no partial results retained.
REQ-028 SHALL leave reset without a spurious run; start must be sampled high after rst_n rises.

Structure
REQ-029 SHALL take state encodings, NUM_VECTORS=4 and the settle counter width from shared package gate_sweep_pkg.
REQ-030 SHALL place the settle down-counter in sub-module settle_timer, which loads SETTLE_CYCLES and flags expiry.

Verification
REQ-031 SHALL cover: OR gate model, truth_table=4'b1110, SETTLE_CYCLES=4 -> done at cycle 24, pass=1, err_count=0, fail_mask=0000.
REQ-032 SHALL cover: gate_y tied 0, truth_table=4'b1110 -> err_count=3, fail_mask=4'b1110, pass=0.
REQ-033 SHALL cover: AND gate model, truth_table=4'b1110 -> err_count=2, fail_mask=4'b0110.
REQ-034 SHALL cover: start pulsed during SETTLE of k=1, and truth_table changed mid-run -> no restart, results match the captured table, done still at cycle 24.
REQ-035 SHALL cover: rst_n low during SETTLE of k=2 -> all outputs reach reset values immediately, and a subsequent start runs a full clean sweep.
REQ-036 SHALL cover: start held high through DONE -> second sweep begins the next cycle, with done low for 24 cycles and err_count re-cleared.

Source files
------------

// File: rtl/gate_sweep_pkg.sv
// Shared definitions for the two-input gate sweep controller:
// state encoding, vector count and counter widths.
package gate_sweep_pkg;

    localparam int NUM_VECTORS  = 4;
    localparam int VEC_W        = $clog2(NUM_VECTORS);
    localparam int SETTLE_CNT_W = 8;
    localparam int ERR_W        = 3;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    function automatic logic is_busy(input state_t s);
        return (s == ST_DRIVE) || (s == ST_SETTLE) || (s == ST_SAMPLE);
    endfunction

endpackage

// File: rtl/gate_sweep_ctrl_settle_timer.sv
// Settle down-counter: loads SETTLE_CYCLES, counts while ticked and
// flags the last settle cycle.
// Ports: clk, rst_n, i_load, i_tick -> o_expired.
module settle_timer
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_tick,
    output logic o_expired
);

    localparam logic [SETTLE_CNT_W-1:0] LOAD_VAL = SETTLE_CNT_W'(SETTLE_CYCLES);
    localparam logic [SETTLE_CNT_W-1:0] ONE      = SETTLE_CNT_W'(1);

    logic [SETTLE_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= LOAD_VAL;
        end else if (i_tick && (r_cnt != '0)) begin
            r_cnt <= r_cnt - ONE;
        end
    end

    // Counter reads N on the first settle cycle, so ONE marks the N-th.
    assign o_expired = i_tick && (r_cnt == ONE);

endmodule

// File: rtl/gate_sweep_ctrl.sv
// Sweeps all four {a,b} vectors into a 2-input gate, samples gate_y after
// a settle delay and compares against a captured truth table.
// Ports: clk, rst_n, start, truth_table[3:0], gate_y in;
//        gate_a, gate_b, busy, done, pass, err_count[2:0], fail_mask[3:0] out.
module gate_sweep_ctrl
    import gate_sweep_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] truth_table,
    input  logic                   gate_y,
    output logic                   gate_a,
    output logic                   gate_b,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_count,
    output logic [NUM_VECTORS-1:0] fail_mask
);

    localparam logic [VEC_W-1:0] LAST_K = VEC_W'(NUM_VECTORS - 1);

    state_t                 r_state;
    logic [VEC_W-1:0]       r_k;
    logic [NUM_VECTORS-1:0] r_tt;
    logic [ERR_W-1:0]       r_err;
    logic [NUM_VECTORS-1:0] r_mask;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_pass;
    logic                   r_a;
    logic                   r_b;

    state_t                 w_state_nxt;
    logic [VEC_W-1:0]       w_k_nxt;
    logic [NUM_VECTORS-1:0] w_tt_nxt;
    logic [ERR_W-1:0]       w_err_nxt;
    logic [NUM_VECTORS-1:0] w_mask_nxt;
    logic                   w_load;
    logic                   w_tick;
    logic                   w_expired;
    logic                   w_busy_nxt;

    settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_load),
        .i_tick   (w_tick),
        .o_expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_k_nxt     = r_k;
        w_tt_nxt    = r_tt;
        w_err_nxt   = r_err;
        w_mask_nxt  = r_mask;
        w_load      = 1'b0;
        w_tick      = 1'b0;
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt = ST_DRIVE;
                    w_k_nxt     = '0;
                    w_tt_nxt    = truth_table;
                    w_err_nxt   = '0;
                    w_mask_nxt  = '0;
                end
            end
            ST_DRIVE: begin
                w_state_nxt = ST_SETTLE;
                w_load      = 1'b1;
            end
            ST_SETTLE: begin
                w_tick = 1'b1;
                if (w_expired) begin
                    w_state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (gate_y != r_tt[r_k]) begin
                    w_mask_nxt[r_k] = 1'b1;
                    w_err_nxt       = r_err + ERR_W'(1);
                end
                if (r_k == LAST_K) begin
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_DRIVE;
                    w_k_nxt     = r_k + VEC_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign w_busy_nxt = is_busy(w_state_nxt);

    // Outputs are flopped from next-state values so they line up with
    // the state they describe while staying free of gate_y comb paths.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k    <= '0;
            r_tt   <= '0;
            r_err  <= '0;
            r_mask <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_pass <= 1'b0;
            r_a    <= 1'b0;
            r_b    <= 1'b0;
        end else begin
            r_k    <= w_k_nxt;
            r_tt   <= w_tt_nxt;
            r_err  <= w_err_nxt;
            r_mask <= w_mask_nxt;
            r_busy <= w_busy_nxt;
            r_done <= (w_state_nxt == ST_DONE);
            r_pass <= (w_state_nxt == ST_DONE) && (w_err_nxt == '0);
            r_a    <= w_busy_nxt && w_k_nxt[1];
            r_b    <= w_busy_nxt && w_k_nxt[0];
        end
    end

    assign gate_a    = r_a;
    assign gate_b    = r_b;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign err_count = r_err;
    assign fail_mask = r_mask;

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Bench for gate_sweep_ctrl: a behavioural gate drives gate_y and each
// cycle of every sweep is checked against results derived from the tables.
module tb_gate_sweep_ctrl;

    localparam int S   = 4;
    localparam int VL  = S + 2;
    localparam int RUN = 4 * VL;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [3:0] truth_table;
    logic       gate_y;
    logic       gate_a;
    logic       gate_b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [2:0] err_count;
    logic [3:0] fail_mask;

    logic [3:0] gm;
    int         nvec = 0;
    int         nerr = 0;

    always #5 clk = ~clk;

    // Gate under control: gm is its truth table indexed by {a,b}.
    assign gate_y = gm[{gate_a, gate_b}];

    gate_sweep_ctrl #(
        .SETTLE_CYCLES(S)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .truth_table(truth_table),
        .gate_y     (gate_y),
        .gate_a     (gate_a),
        .gate_b     (gate_b),
        .busy       (busy),
        .done       (done),
        .pass       (pass),
        .err_count  (err_count),
        .fail_mask  (fail_mask)
    );

    task automatic chk(input string tag, input logic [7:0] obs,
                       input logic [7:0] exp);
        nvec++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_busy"}, 8'(busy), 8'd0);
        chk({tag, "_done"}, 8'(done), 8'd0);
        chk({tag, "_pass"}, 8'(pass), 8'd0);
        chk({tag, "_ab"}, 8'({gate_a, gate_b}), 8'd0);
    endtask

    // j = clock edges since the edge that accepted start.
    task automatic check_step(input int j, input logic [3:0] tt,
                              input logic [3:0] g);
        int         nd;
        logic [3:0] pm;
        logic [1:0] ek;
        logic       dn;
        nd = j / VL;
        if (nd > 4) nd = 4;
        pm = (tt ^ g) & 4'((1 << nd) - 1);
        ek = (j < RUN) ? 2'(j / VL) : 2'd0;
        dn = (j == RUN);
        chk($sformatf("busy@%0d", j), 8'(busy), 8'(j < RUN));
        chk($sformatf("done@%0d", j), 8'(done), 8'(dn));
        chk($sformatf("pass@%0d", j), 8'(pass), 8'(dn && (pm == 4'd0)));
        chk($sformatf("ab@%0d", j), 8'({gate_a, gate_b}), 8'(ek));
        chk($sformatf("err@%0d", j), 8'(err_count), 8'($countones(pm)));
        chk($sformatf("mask@%0d", j), 8'(fail_mask), 8'(pm));
    endtask

    task automatic do_abort();
        #2;
        rst_n = 1'b0;
        #1;
        chk_idle("abort");
        chk("abort_err", 8'(err_count), 8'd0);
        chk("abort_mask", 8'(fail_mask), 8'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk_idle("postrst");
    endtask

    task automatic do_run(input logic [3:0] tt, input logic [3:0] g,
                          input bit noise, input bit keep,
                          input int abort_at);
        gm          = g;
        truth_table = tt;
        start       = 1'b1;
        tick();
        start = 1'b0;
        for (int j = 0; j <= RUN; j++) begin
            if (j > 0) tick();
            check_step(j, tt, g);
            if (j == abort_at) begin
                do_abort();
                return;
            end
            if (noise && (j < RUN)) begin
                start       = 1'($urandom);
                truth_table = 4'($urandom);
                if (j == VL + 2) begin
                    start       = 1'b1;
                    truth_table = ~tt;
                end
            end
        end
        start = keep;
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        truth_table = 4'd0;
        gm          = 4'd0;
        tick();
        tick();
        chk_idle("reset");
        chk("reset_err", 8'(err_count), 8'd0);
        chk("reset_mask", 8'(fail_mask), 8'd0);
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk_idle("no_spurious");

        do_run(4'b1110, 4'b1110, 1'b0, 1'b0, -1);
        do_run(4'b1110, 4'b0000, 1'b0, 1'b0, -1);
        do_run(4'b1110, 4'b1000, 1'b0, 1'b0, -1);
        do_run(4'b1110, 4'b1110, 1'b1, 1'b0, -1);
        do_run(4'b1110, 4'b0000, 1'b1, 1'b0, -1);
        do_run(4'b1110, 4'b0000, 1'b0, 1'b0, 2 * VL + 2);
        do_run(4'b1110, 4'b1110, 1'b0, 1'b0, -1);
        do_run(4'b1110, 4'b0000, 1'b0, 1'b1, -1);
        do_run(4'b1110, 4'b1110, 1'b0, 1'b1, -1);
        do_run(4'b0110, 4'b0110, 1'b0, 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            do_run(4'($urandom), 4'($urandom), 1'($urandom), 1'b0, -1);
        end

        tick();
        tick();
        chk("final_done", 8'(done), 8'd1);
        chk("final_busy", 8'(busy), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
